// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the round-robin arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DIV_WIDTH = 24
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [2:0]           grant_id;
  logic                 busy;

  logic [1:0]           cfg_data_bits;
  logic                 cfg_has_parity;
  logic [1:0]           cfg_parity_mode;
  logic                 cfg_extra_stop;
  logic [DIV_WIDTH-1:0] cfg_divisor;

  logic                 tx_ready;
  logic                 tx_transmit;
  logic [7:0]           tx_data;
  logic [1:0]           tx_data_bits;
  logic                 tx_has_parity;
  logic [1:0]           tx_parity_mode;
  logic                 tx_extra_stop;
  logic [DIV_WIDTH-1:0] tx_divisor;

  modport slave (
    input  req_valid, req_data,
    input  cfg_data_bits, cfg_has_parity, cfg_parity_mode, cfg_extra_stop, cfg_divisor,
    input  tx_ready,
    output req_ack, grant_id, busy,
    output tx_transmit, tx_data, tx_data_bits, tx_has_parity, tx_parity_mode,
    output tx_extra_stop, tx_divisor
  );

  modport master (
    output req_valid, req_data,
    output cfg_data_bits, cfg_has_parity, cfg_parity_mode, cfg_extra_stop, cfg_divisor,
    output tx_ready,
    input  req_ack, grant_id, busy,
    input  tx_transmit, tx_data, tx_data_bits, tx_has_parity, tx_parity_mode,
    input  tx_extra_stop, tx_divisor
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Sequences the transmit pulse, a guard window and the wait for tx_ready; config only changes between frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int DIV_WIDTH    = 24
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2:0]           r_rr_ptr,      w_rr_ptr_next;
  logic [GW-1:0]        r_guard_cnt,   w_guard_cnt_next;
  logic                 r_tx_transmit, w_tx_transmit_next;
  logic [7:0]           r_tx_data,     w_tx_data_next;
  logic [NUM_REQ-1:0]   r_req_ack,     w_req_ack_next;
  logic [2:0]           r_grant_id,    w_grant_id_next;
  logic                 r_busy,        w_busy_next;
  logic [1:0]           r_data_bits,   w_data_bits_next;
  logic                 r_has_parity,  w_has_parity_next;
  logic [1:0]           r_parity_mode, w_parity_mode_next;
  logic                 r_extra_stop,  w_extra_stop_next;
  logic [DIV_WIDTH-1:0] r_divisor,     w_divisor_next;

  logic [7:0]           w_req_bytes [NUM_REQ];
  logic                 w_found;
  logic [2:0]           w_sel;
  logic [7:0]           w_sel_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = bus.req_data[8*gi +: 8];
  end

  // Scan rr_ptr+1, rr_ptr+2, ... by matching each constant (offset, index) pair against the pointer.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_sel_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && bus.req_valid[i] &&
            (r_rr_ptr == 3'((i - k + NUM_REQ) % NUM_REQ))) begin
          w_found    = 1'b1;
          w_sel      = 3'(i);
          w_sel_data = w_req_bytes[i];
        end
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_rr_ptr_next      = r_rr_ptr;
    w_guard_cnt_next   = r_guard_cnt;
    w_tx_transmit_next = 1'b0;
    w_req_ack_next     = '0;
    w_tx_data_next     = r_tx_data;
    w_grant_id_next    = r_grant_id;
    w_data_bits_next   = r_data_bits;
    w_has_parity_next  = r_has_parity;
    w_parity_mode_next = r_parity_mode;
    w_extra_stop_next  = r_extra_stop;
    w_divisor_next     = r_divisor;

    case (r_state)
      S_IDLE: begin
        if (bus.tx_ready && w_found) begin
          w_state_next       = S_SEND;
          w_tx_transmit_next = 1'b1;
          w_tx_data_next     = w_sel_data;
          w_grant_id_next    = w_sel;
          w_rr_ptr_next      = w_sel;
          for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ack_next[i] = (w_sel == 3'(i));
          end
        end else begin
          w_data_bits_next   = bus.cfg_data_bits;
          w_has_parity_next  = bus.cfg_has_parity;
          w_parity_mode_next = bus.cfg_parity_mode;
          w_extra_stop_next  = bus.cfg_extra_stop;
          w_divisor_next     = bus.cfg_divisor;
        end
      end
      S_SEND: begin
        w_guard_cnt_next = GW'(GUARD_CYCLES);
        w_state_next     = S_GUARD;
      end
      S_GUARD: begin
        // The transmitter may still report ready from before the pulse; ignore it here.
        w_guard_cnt_next = r_guard_cnt - GW'(1);
        if (r_guard_cnt <= GW'(1)) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.tx_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= 3'(NUM_REQ - 1);
      r_guard_cnt   <= '0;
      r_tx_transmit <= 1'b0;
      r_tx_data     <= '0;
      r_req_ack     <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_data_bits   <= '0;
      r_has_parity  <= 1'b0;
      r_parity_mode <= '0;
      r_extra_stop  <= 1'b0;
      r_divisor     <= DIV_WIDTH'(10);
    end else begin
      r_state       <= w_state_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_guard_cnt   <= w_guard_cnt_next;
      r_tx_transmit <= w_tx_transmit_next;
      r_tx_data     <= w_tx_data_next;
      r_req_ack     <= w_req_ack_next;
      r_grant_id    <= w_grant_id_next;
      r_busy        <= w_busy_next;
      r_data_bits   <= w_data_bits_next;
      r_has_parity  <= w_has_parity_next;
      r_parity_mode <= w_parity_mode_next;
      r_extra_stop  <= w_extra_stop_next;
      r_divisor     <= w_divisor_next;
    end
  end

  assign bus.tx_transmit    = r_tx_transmit;
  assign bus.tx_data        = r_tx_data;
  assign bus.req_ack        = r_req_ack;
  assign bus.grant_id       = r_grant_id;
  assign bus.busy           = r_busy;
  assign bus.tx_data_bits   = r_data_bits;
  assign bus.tx_has_parity  = r_has_parity;
  assign bus.tx_parity_mode = r_parity_mode;
  assign bus.tx_extra_stop  = r_extra_stop;
  assign bus.tx_divisor     = r_divisor;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a simple transmitter model holds tx_ready low for a frame
// after each pulse, and every pulse's grant_id/tx_data is logged as the received byte stream.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DIV_WIDTH = 24;
  localparam int FRAME     = 6;

  logic clk = 1'b0;
  logic rst;
  logic force_busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int model_cnt = 0;
  int ack1_cnt  = 0;
  logic [2:0] grant_q [$];
  logic [7:0] data_q  [$];

  logic [2:0] exp_g3 [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [7:0] exp_d3 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
  logic [2:0] exp_g6 [3] = '{3'd0, 3'd2, 3'd0};

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DIV_WIDTH(DIV_WIDTH)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .GUARD_CYCLES(2),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.tx_ready = !force_busy && (model_cnt == 0);

  // Transmitter stand-in and receive log, both sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.tx_transmit === 1'b1) begin
      model_cnt <= FRAME;
      grant_q.push_back(bus.grant_id);
      data_q.push_back(bus.tx_data);
      $display("tx pulse: grant_id=%0d tx_data=%02h tx_divisor=%0d", bus.grant_id, bus.tx_data, bus.tx_divisor);
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
    end
    if (bus.req_ack[1] === 1'b1) ack1_cnt <= ack1_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!(bus.busy === 1'b0 && bus.tx_ready === 1'b1) && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_idle_timeout"}, 32'(cyc < 100), 32'd1);
  endtask

  task automatic wait_transmit(input string tag);
    int cyc = 0;
    while (bus.tx_transmit !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_pulse_timeout"}, 32'(cyc < 100), 32'd1);
  endtask

  task automatic wait_pulses(input int base, input int n, input string tag);
    int cyc = 0;
    while (grant_q.size() < base + n && cyc < 300) begin
      tick();
      cyc++;
    end
    check({tag, "_count_timeout"}, 32'(cyc < 300), 32'd1);
  endtask

  initial begin
    int base;
    int a1;

    rst                 = 1'b1;
    force_busy          = 1'b0;
    bus.req_valid       = '0;
    bus.req_data        = '0;
    bus.cfg_data_bits   = 2'd3;
    bus.cfg_has_parity  = 1'b1;
    bus.cfg_parity_mode = 2'b01;
    bus.cfg_extra_stop  = 1'b0;
    bus.cfg_divisor     = 24'd33;
    tick();
    tick();

    // Reset state
    check("rst_transmit", 32'(bus.tx_transmit), 32'd0);
    check("rst_busy",     32'(bus.busy),        32'd0);
    check("rst_grant",    32'(bus.grant_id),    32'd0);
    check("rst_ack",      32'(bus.req_ack),     32'd0);
    check("rst_data",     32'(bus.tx_data),     32'd0);
    check("rst_divisor",  32'(bus.tx_divisor),  32'd10);
    check("rst_bits",     32'(bus.tx_data_bits), 32'd0);
    check("rst_parity",   32'(bus.tx_has_parity), 32'd0);

    rst = 1'b0;
    tick();
    check("cfg_track_div",  32'(bus.tx_divisor),     32'd33);
    check("cfg_track_bits", 32'(bus.tx_data_bits),   32'd3);
    check("cfg_track_pm",   32'(bus.tx_parity_mode), 32'd1);
    bus.cfg_divisor = 24'd10;
    tick();

    // Single request from requester 0: pulse on the next edge
    bus.req_data  = 32'h0000_0060;
    bus.req_valid = 4'b0001;
    tick();
    check("t2_transmit", 32'(bus.tx_transmit), 32'd1);
    check("t2_data",     32'(bus.tx_data),     32'h60);
    check("t2_ack",      32'(bus.req_ack),     32'b0001);
    check("t2_grant",    32'(bus.grant_id),    32'd0);
    check("t2_busy",     32'(bus.busy),        32'd1);
    bus.req_valid = 4'b0000;
    tick();
    check("t2_pulse_width", 32'(bus.tx_transmit), 32'd0);
    check("t2_ack_width",   32'(bus.req_ack),     32'd0);
    check("t2_data_hold",   32'(bus.tx_data),     32'h60);
    wait_ready("t2");

    // Reset while in GUARD abandons the frame
    bus.req_data  = 32'h0000_1100;
    bus.req_valid = 4'b0010;
    tick();
    check("t1_grant", 32'(bus.grant_id), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t1_transmit", 32'(bus.tx_transmit), 32'd0);
    check("t1_busy",     32'(bus.busy),        32'd0);
    check("t1_ack",      32'(bus.req_ack),     32'd0);
    check("t1_divisor",  32'(bus.tx_divisor),  32'd10);
    check("t1_grant_rst", 32'(bus.grant_id),   32'd0);
    bus.req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    check("t1_post_busy",     32'(bus.busy),        32'd0);
    check("t1_post_transmit", 32'(bus.tx_transmit), 32'd0);
    wait_ready("t1");

    // All four requesters continuously valid: strict rotation from the reset pointer
    base = grant_q.size();
    bus.req_data  = 32'hA3A2_A1A0;
    bus.req_valid = 4'b1111;
    wait_pulses(base, 5, "t3");
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      if (base + k < grant_q.size()) begin
        check($sformatf("t3_grant%0d", k), 32'(grant_q[base + k]), 32'(exp_g3[k]));
        check($sformatf("t3_byte%0d", k),  32'(data_q[base + k]),  32'(exp_d3[k]));
      end
    end
    wait_ready("t3");

    // Config change during WAIT is held until IDLE
    bus.req_data  = 32'h0000_0044;
    bus.req_valid = 4'b0001;
    wait_transmit("t4a");
    bus.req_valid = 4'b0000;
    tick(); tick(); tick(); tick();
    bus.cfg_divisor = 24'd20;
    check("t4_wait_busy", 32'(bus.busy),       32'd1);
    check("t4_frozen0",   32'(bus.tx_divisor), 32'd10);
    tick();
    check("t4_frozen1",   32'(bus.tx_divisor), 32'd10);
    wait_ready("t4");
    check("t4_idle_entry", 32'(bus.tx_divisor), 32'd10);
    tick();
    check("t4_applied",   32'(bus.tx_divisor), 32'd20);
    bus.req_valid = 4'b0001;
    wait_transmit("t4b");
    check("t4_pulse_div",   32'(bus.tx_divisor), 32'd20);
    check("t4_pulse_grant", 32'(bus.grant_id),   32'd0);
    bus.req_valid = 4'b0000;
    wait_ready("t4c");

    // tx_ready low blocks the grant; request stays pending
    force_busy    = 1'b1;
    bus.req_data  = 32'h005C_0000;
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t5_no_pulse%0d", k), 32'(bus.tx_transmit), 32'd0);
    end
    check("t5_no_ack",  32'(bus.req_ack), 32'd0);
    check("t5_no_busy", 32'(bus.busy),    32'd0);
    force_busy = 1'b0;
    tick();
    check("t5_transmit", 32'(bus.tx_transmit), 32'd1);
    check("t5_grant",    32'(bus.grant_id),    32'd2);
    check("t5_ack",      32'(bus.req_ack),     32'b0100);
    check("t5_data",     32'(bus.tx_data),     32'h5C);
    bus.req_valid = 4'b0000;
    wait_ready("t5");

    // Requester 1 withdraws before its turn
    base = grant_q.size();
    a1   = ack1_cnt;
    bus.req_data  = 32'h0012_1110;
    bus.req_valid = 4'b0111;
    wait_transmit("t6");
    bus.req_valid = 4'b0101;
    wait_pulses(base, 3, "t6");
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      if (base + k < grant_q.size()) begin
        check($sformatf("t6_grant%0d", k), 32'(grant_q[base + k]), 32'(exp_g6[k]));
      end
    end
    tick();
    check("t6_no_ack1", 32'(ack1_cnt - a1), 32'd0);
    wait_ready("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
